// File: rtl/gfx_shader_group_queue_pkg.sv
// Shared types for the shader group loop-back scheduler.
package gfx;
   localparam int SHADER_GROUPS = 16;
   localparam int GROUP_BITS    = $clog2(SHADER_GROUPS);

   typedef logic [GROUP_BITS-1:0]    group_id;
   typedef logic [SHADER_GROUPS-1:0] group_mask;
endpackage

// File: rtl/gfx_shader_group_queue_if.sv
// Writeback-loop input, fetch handshake and status bundle of the group queue.
interface gfx_shader_group_queue_if
   import gfx::*;
#(
   parameter int GROUPS     = SHADER_GROUPS,
   parameter int GROUP_BITS = $clog2(GROUPS)
);
   logic                  loop_valid;
   logic [GROUP_BITS-1:0] loop_group;
   logic                  flush;
   logic                  fetch_valid;
   logic [GROUP_BITS-1:0] fetch_group;
   logic                  fetch_ready;
   logic [GROUPS-1:0]     queued;
   logic [GROUP_BITS:0]   count;
   logic                  dup_err;

   modport master (
      output loop_valid, loop_group, flush, fetch_ready,
      input  fetch_valid, fetch_group, queued, count, dup_err
   );

   modport slave (
      input  loop_valid, loop_group, flush, fetch_ready,
      output fetch_valid, fetch_group, queued, count, dup_err
   );
endinterface

// File: rtl/gfx_shader_group_queue_ring.sv
// Plain ring of group IDs: two wrapping pointers and the entry array, nothing else.
module gfx_shader_group_ring
   import gfx::*;
#(
   parameter int GROUPS     = SHADER_GROUPS,
   parameter int GROUP_BITS = $clog2(GROUPS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [GROUP_BITS-1:0] wdata,
   output logic [GROUP_BITS-1:0] rdata
);
   logic [GROUP_BITS-1:0] rd_ptr;
   logic [GROUP_BITS-1:0] wr_ptr;
   logic [GROUP_BITS-1:0] mem [GROUPS];

   // Depth is a power of two, so pointers wrap by plain overflow.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + GROUP_BITS'(1);
         if (pop)  rd_ptr <= rd_ptr + GROUP_BITS'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   assign rdata = mem[rd_ptr];
endmodule

// File: rtl/gfx_shader_group_queue.sv
// Loop-back group scheduler: residency bitmap guarantees each group is queued once.
module gfx_shader_group_queue
   import gfx::*;
#(
   parameter int GROUPS     = SHADER_GROUPS,
   parameter int GROUP_BITS = $clog2(GROUPS)
) (
   input logic                     clk,
   input logic                     rst,
   gfx_shader_group_queue_if.slave bus
);
   logic [GROUPS-1:0]     queued_q, queued_d;
   logic [GROUPS-1:0]     pop_mask, push_mask;
   logic [GROUP_BITS:0]   count_q, count_d;
   logic                  dup_q;
   logic                  pop, push, resident, dup;
   logic [GROUP_BITS-1:0] head;

   gfx_shader_group_ring #(.GROUPS(GROUPS), .GROUP_BITS(GROUP_BITS)) u_ring (
      .clk   (clk),
      .rst   (rst),
      .clear (bus.flush),
      .push  (push),
      .pop   (pop & ~bus.flush),
      .wdata (bus.loop_group),
      .rdata (head)
   );

   // Residency is judged after this cycle's pop-clear, so the group leaving
   // the head may re-enter at the tail in the same cycle.
   always_comb begin
      pop       = (count_q != '0) & bus.fetch_ready;
      pop_mask  = '0;
      if (pop) pop_mask[head] = 1'b1;
      resident  = queued_q[bus.loop_group] & ~pop_mask[bus.loop_group];
      push      = bus.loop_valid & ~resident & ~bus.flush;
      dup       = bus.loop_valid &  resident & ~bus.flush;
      push_mask = '0;
      if (push) push_mask[bus.loop_group] = 1'b1;
      queued_d  = (queued_q & ~pop_mask) | push_mask;
      count_d   = count_q + {{GROUP_BITS{1'b0}}, push} - {{GROUP_BITS{1'b0}}, pop};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         queued_q <= '0;
         count_q  <= '0;
         dup_q    <= 1'b0;
      end else if (bus.flush) begin
         queued_q <= '0;
         count_q  <= '0;
      end else begin
         queued_q <= queued_d;
         count_q  <= count_d;
         if (dup) dup_q <= 1'b1;
      end
   end

   assign bus.fetch_valid = (count_q != '0);
   assign bus.fetch_group = head;
   assign bus.queued      = queued_q;
   assign bus.count       = count_q;
   assign bus.dup_err     = dup_q;
endmodule
